wb_host_initiator: RTL and testbench
====================================

# wb_host_initiator

Wishbone classic initiator that drives the accelerator's 32-bit Wishbone slave port from a simple command/response stream interface. It converts single-word and incrementing-burst read/write commands into Wishbone cycles, returns one response per beat and aborts stalled cycles with a timeout. It sits in the block-level and FPGA bring-up environments in place of the management SoC, and on-chip as the engine for LA-driven self-test.

## Interface
Parameters:
- TIMEOUT, 255, cycles STB may stay high without ACK before abort (1..65535)
- ADR_STEP, 4, byte increment of address per burst beat

Ports (all synchronous to wb_clk_i):
- wb_clk_i  input  1  single clock
- wb_rst_ni  input  1  reset, asynchronous assert, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&ready
- cmd_we  input  1  1 = write, 0 = read
- cmd_adr  input  32  first-beat byte address
- cmd_sel  input  4  byte selects, all beats
- cmd_len  input  4  beats minus one (0 = single, 15 = 16 beats)
- wdat_valid  input  1  write data present
- wdat_ready  output  1  write data consumed when valid&ready
- wdat  input  32  write data, one word per write beat
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&ready
- rsp_dat  output  32  read data; 0 for writes and errors
- rsp_err  output  1  beat timed out
- rsp_last  output  1  final response of the command
- wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone control
- wbm_adr_o  output  32; wbm_dat_o  output  32; wbm_sel_o  output  4
- wbm_dat_i  input  32; wbm_ack_i  input  1
- busy  output  1  high from command accept until last response consumed

## Operation
- States: IDLE, WDAT, BUS, RESP.
- IDLE: cmd_ready=1. On accept, latch we/adr/sel/len into registers, beat counter=len. Go WDAT if we else BUS.
- WDAT: wdat_ready=1. On wdat handshake, latch wdat into wbm_dat_o, go BUS.
- BUS: cyc=stb=1, adr/we/sel/dat from registers. Timeout counter increments each BUS cycle, cleared on entry.
  - ack=1: capture wbm_dat_i (reads) into rsp_dat, rsp_err=0, rsp_last=(beat counter==0); go RESP.
  - no ack and counter reaches TIMEOUT-1: rsp_err=1, rsp_dat=0, rsp_last=1; go RESP; command terminated.
- RESP: stb=0; cyc stays 1 only if more beats remain and no error, else 0. rsp_valid=1. On rsp handshake: if rsp_last go IDLE; else adr += ADR_STEP (32-bit wrap, 0xFFFFFFFC+4 = 0), counter -= 1, go WDAT/BUS.
- ack arriving while stb=0 is ignored.
- After timeout, remaining write data for the aborted command is NOT consumed; upstream flushes it.
- wbm_dat_o holds last written value outside write beats; wbm_we_o holds command we while cyc=1, else 0.

## Timing
- Reset (async on wb_rst_ni low): state IDLE; cyc, stb, we, rsp_valid, rsp_err, rsp_last, wdat_ready, busy = 0; adr, dat_o, sel, rsp_dat = 0; cmd_ready=1 once reset released. Reset mid-cycle drops cyc/stb immediately; no response issued.
- All Wishbone and rsp outputs are registered.
- Read, zero-wait slave: accept at edge 0, stb high cycle 1, ack sampled edge 1, rsp_valid high cycle 2 → 2-cycle minimum latency. Each extra ack-wait cycle adds 1.
- Burst beat spacing minimum 2 cycles (BUS, RESP) for reads; writes add ≥1 WDAT cycle.
- Backpressure: rsp_ready low holds RESP indefinitely; stb stays 0; no timeout counting in RESP.
- Timeout: error response at cycle TIMEOUT+1 after stb rises with no ack.
- cmd_ready and wdat_ready are never high in the same cycle.

## Test plan
- Single read, adr 0x3000_0000, slave acks cycle 1 with 0xDEADBEEF -> one stb pulse, rsp_valid cycle 2, rsp_dat=0xDEADBEEF, err=0, last=1.
- Write burst len=3 from 0x3000_0010, wdat 1,2,3,4, 2-cycle ack delay -> four stb pulses at adr 0x10/0x14/0x18/0x1C with dat 1..4, cyc continuous, four responses, last only on 4th.
- Read, no ack, TIMEOUT=8 -> stb high exactly 8 cycles, cyc/stb drop, rsp_err=1, rsp_dat=0, last=1, returns to IDLE.
- Read burst len=1, rsp_ready low 5 cycles after first beat -> stb stays 0 during stall, second beat issues only after handshake, no timeout.
- Burst starting adr 0xFFFF_FFFC len=1 -> second beat adr 0x0000_0000.
- Reset asserted during BUS of a write -> cyc/stb/rsp_valid 0 asynchronously, cmd_ready=1 after release, next command executes normally.

Source files
------------

// File: rtl/wb_host_initiator.sv
// rtl/wb_host_initiator.sv - Wishbone classic initiator driven by a command/write-data/response stream
module wb_host_initiator #(
  parameter int TIMEOUT  = 255,
  parameter int ADR_STEP = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,
  input  logic        wdat_valid,
  output logic        wdat_ready,
  input  logic [31:0] wdat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WDAT = 2'd1,
    BUS  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Last timeout count value before the beat is abandoned, and address step per beat.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] ADR_INC  = 32'(ADR_STEP);

  state_t      state;
  logic        we_q;
  logic [3:0]  beat_cnt;
  logic [15:0] tmo_cnt;

  // Command sequencer: every bus and stream output is a register owned by this FSM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      beat_cnt   <= 4'd0;
      tmo_cnt    <= 16'd0;
      cmd_ready  <= 1'b0;
      wdat_ready <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= 32'd0;
      rsp_err    <= 1'b0;
      rsp_last   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_adr_o  <= 32'd0;
      wbm_dat_o  <= 32'd0;
      wbm_sel_o  <= 4'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up on the first clock after reset release
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            we_q      <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_sel_o <= cmd_sel;
            beat_cnt  <= cmd_len;
            if (cmd_we) begin
              wdat_ready <= 1'b1;
              state      <= WDAT;
            end else begin
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b0;
              tmo_cnt   <= 16'd0;
              state     <= BUS;
            end
          end
        end

        WDAT: begin
          // cyc is left untouched so it stays asserted across burst beats
          if (wdat_valid && wdat_ready) begin
            wdat_ready <= 1'b0;
            wbm_dat_o  <= wdat;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= 1'b1;
            tmo_cnt    <= 16'd0;
            state      <= BUS;
          end
        end

        BUS: begin
          if (wbm_ack_i) begin
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_dat   <= we_q ? 32'd0 : wbm_dat_i;
            rsp_last  <= (beat_cnt == 4'd0);
            if (beat_cnt == 4'd0) begin
              wbm_cyc_o <= 1'b0;
              wbm_we_o  <= 1'b0;
            end
            state <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abort: the rest of the command is dropped, pending write data is left upstream
            wbm_stb_o <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= 32'd0;
            rsp_last  <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        RESP: begin
          // Response is held with stb low for as long as the consumer stalls; no timeout here
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              wbm_adr_o <= wbm_adr_o + ADR_INC;
              beat_cnt  <= beat_cnt - 4'd1;
              if (we_q) begin
                wdat_ready <= 1'b1;
                state      <= WDAT;
              end else begin
                wbm_stb_o <= 1'b1;
                tmo_cnt   <= 16'd0;
                state     <= BUS;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_initiator.sv
// tb/tb_wb_host_initiator.sv - directed self-checking bench for wb_host_initiator
module tb_wb_host_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel, cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_last;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o, dat_i;
  logic [3:0]  sel;
  logic        ack;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // slave model controls (written by main only)
  logic        slave_en;
  int          ack_delay;
  logic [31:0] slave_rdata;

  // monitor state (written by monitor only)
  int          cyc_cnt = 0;
  int          np = 0;
  int          stb_cycles = 0;
  int          cyc_falls = 0;
  int          stb_in_rsp = 0;
  int          rdy_overlap = 0;
  logic        stb_q = 1'b0;
  logic        cyc_q = 1'b0;
  logic [31:0] pulse_adr [64];
  logic [31:0] pulse_dat [64];
  logic        pulse_we  [64];

  // captured by tasks
  int          acc_cyc, rsp_cyc;
  logic [31:0] r_dat;
  logic        r_err, r_last;

  wb_host_initiator #(.TIMEOUT(8), .ADR_STEP(4)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .wdat_valid(wdat_valid),
    .wdat_ready(wdat_ready),
    .wdat      (wdat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_sel_o (sel),
    .wbm_dat_i (dat_i),
    .wbm_ack_i (ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    stb_q <= stb;
    cyc_q <= cyc;
    if (stb) stb_cycles <= stb_cycles + 1;
    if (cyc_q && !cyc) cyc_falls <= cyc_falls + 1;
    if (stb && rsp_valid) stb_in_rsp <= stb_in_rsp + 1;
    if (cmd_ready && wdat_ready) rdy_overlap <= rdy_overlap + 1;
    if (stb && !stb_q && np < 64) begin
      pulse_adr[np] <= adr;
      pulse_dat[np] <= dat_o;
      pulse_we[np]  <= we;
      np <= np + 1;
    end
  end

  // Wishbone slave: acks after ack_delay wait cycles, read data = slave_rdata ^ address
  initial begin
    int wcnt;
    wcnt  = 0;
    ack   = 1'b0;
    dat_i = 32'd0;
    forever begin
      @(negedge clk);
      if (stb && slave_en && wcnt == ack_delay) begin
        ack   = 1'b1;
        dat_i = slave_rdata ^ adr;
      end else begin
        ack   = 1'b0;
        dat_i = 32'd0;
        if (stb) wcnt++;
        else     wcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // all stream tasks start and end on a falling edge
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [3:0] l);
    bit ok;
    ok = 0;
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_len = l;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    acc_cyc   = cyc_cnt;
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_wdat(input logic [31:0] d);
    bit ok;
    ok = 0;
    wdat_valid = 1'b1; wdat = d;
    for (int i = 0; i < 50; i++) begin
      if (wdat_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    wdat_valid = 1'b0;
    if (!ok) check("wdat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic get_rsp(input int hold);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        ok      = 1;
        rsp_cyc = cyc_cnt;
        for (int h = 0; h < hold; h++) @(negedge clk);
        r_dat  = rsp_dat;
        r_err  = rsp_err;
        r_last = rsp_last;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int b_np, b_stb, b_fall, b_sir;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0; cmd_sel = 4'd0; cmd_len = 4'd0;
    wdat_valid = 1'b0; wdat = 32'd0; rsp_ready = 1'b0;
    slave_en = 1'b1; ack_delay = 0; slave_rdata = 32'd0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_adr", adr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // single zero-wait read
    b_np = np; b_stb = stb_cycles;
    ack_delay = 0; slave_rdata = 32'hDEADBEEF ^ 32'h3000_0000;
    send_cmd(1'b0, 32'h3000_0000, 4'hF, 4'd0);
    check("rd_busy", {31'd0, busy}, 32'd1);
    get_rsp(0);
    check("rd_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
    check("rd_dat", r_dat, 32'hDEADBEEF);
    check("rd_err", {31'd0, r_err}, 32'd0);
    check("rd_last", {31'd0, r_last}, 32'd1);
    check("rd_pulses", 32'(np - b_np), 32'd1);
    check("rd_stb_cycles", 32'(stb_cycles - b_stb), 32'd1);
    check("rd_adr", pulse_adr[b_np], 32'h3000_0000);
    check("rd_we", {31'd0, pulse_we[b_np]}, 32'd0);
    check("rd_busy_after", {31'd0, busy}, 32'd0);

    // 4-beat write burst, 2 wait states per beat
    b_np = np; b_stb = stb_cycles; b_fall = cyc_falls;
    ack_delay = 2;
    send_cmd(1'b1, 32'h3000_0010, 4'hF, 4'd3);
    for (int i = 0; i < 4; i++) begin
      send_wdat(32'(i + 1));
      get_rsp(0);
      check($sformatf("wr_dat_b%0d", i), r_dat, 32'd0);
      check($sformatf("wr_err_b%0d", i), {31'd0, r_err}, 32'd0);
      check($sformatf("wr_last_b%0d", i), {31'd0, r_last}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("wr_pulses", 32'(np - b_np), 32'd4);
    check("wr_stb_cycles", 32'(stb_cycles - b_stb), 32'd12);
    check("wr_cyc_falls", 32'(cyc_falls - b_fall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_adr_b%0d", i), pulse_adr[b_np + i], 32'h3000_0010 + 32'(4 * i));
      check($sformatf("wr_wdat_b%0d", i), pulse_dat[b_np + i], 32'(i + 1));
      check($sformatf("wr_we_b%0d", i), {31'd0, pulse_we[b_np + i]}, 32'd1);
    end
    check("wr_dat_o_hold", dat_o, 32'd4);
    check("wr_we_after", {31'd0, we}, 32'd0);

    // read with no ack -> timeout after 8 stb cycles
    b_np = np; b_stb = stb_cycles;
    slave_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0040, 4'hF, 4'd0);
    get_rsp(0);
    check("to_latency", 32'(rsp_cyc - acc_cyc), 32'd8);
    check("to_stb_cycles", 32'(stb_cycles - b_stb), 32'd8);
    check("to_pulses", 32'(np - b_np), 32'd1);
    check("to_err", {31'd0, r_err}, 32'd1);
    check("to_dat", r_dat, 32'd0);
    check("to_last", {31'd0, r_last}, 32'd1);
    check("to_cyc_after", {31'd0, cyc}, 32'd0);
    check("to_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    slave_en = 1'b1;

    // 2-beat read with 5-cycle response stall after the first beat
    b_np = np; b_stb = stb_cycles; b_sir = stb_in_rsp;
    ack_delay = 0; slave_rdata = 32'h1111_0000;
    send_cmd(1'b0, 32'h4000_0100, 4'h3, 4'd1);
    get_rsp(5);
    check("bp_dat_b0", r_dat, 32'h5111_0100);
    check("bp_last_b0", {31'd0, r_last}, 32'd0);
    check("bp_pulses_mid", 32'(np - b_np), 32'd1);
    get_rsp(0);
    check("bp_dat_b1", r_dat, 32'h5111_0104);
    check("bp_err_b1", {31'd0, r_err}, 32'd0);
    check("bp_last_b1", {31'd0, r_last}, 32'd1);
    check("bp_stb_cycles", 32'(stb_cycles - b_stb), 32'd2);
    check("bp_stb_in_rsp", 32'(stb_in_rsp - b_sir), 32'd0);
    check("bp_sel", {28'd0, sel}, 32'h3);

    // address wrap
    b_np = np;
    slave_rdata = 32'h0;
    send_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 4'd1);
    get_rsp(0);
    get_rsp(0);
    check("wrap_pulses", 32'(np - b_np), 32'd2);
    check("wrap_adr_b0", pulse_adr[b_np], 32'hFFFF_FFFC);
    check("wrap_adr_b1", pulse_adr[b_np + 1], 32'h0000_0000);
    check("wrap_dat_b1", r_dat, 32'h0000_0000);

    // reset during the bus phase of a write
    slave_en = 1'b0;
    send_cmd(1'b1, 32'h3000_0080, 4'hF, 4'd0);
    send_wdat(32'hCAFE_0001);
    check("mr_stb_before", {31'd0, stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_cyc", {31'd0, cyc}, 32'd0);
    check("mr_stb", {31'd0, stb}, 32'd0);
    check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    slave_en = 1'b1; ack_delay = 1; slave_rdata = 32'h0F0F_0000;
    send_cmd(1'b0, 32'h3000_0020, 4'hF, 4'd0);
    get_rsp(0);
    check("mr_next_latency", 32'(rsp_cyc - acc_cyc), 32'd2);
    check("mr_next_dat", r_dat, 32'h3F0F_0020);
    check("mr_next_last", {31'd0, r_last}, 32'd1);

    check("ready_overlap", 32'(rdy_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
